// File: rtl/mycpu_alu_arb.sv
// mycpu_alu_arb
//   Arbitrates two requesters onto one shared, purely combinational ALU. At most one
//   operation is in flight: IDLE (grant/accept) -> EXEC (drive ALU, capture) -> RESP
//   (hold result until consumed). The opcode is opaque and passed straight through.
//
// Ports
//   clk, resetn         clock, asynchronous active-low reset
//   flush               synchronous abort of the in-flight operation
//   rN_req_*            request channel N (valid/ready, op, a, b), N = 0,1
//   rN_rsp_*            response channel N (valid/ready, data, ovf)
//   alu_A/alu_B/alu_op  operands/opcode to the shared ALU
//   alu_result/overflow combinational ALU outputs
module mycpu_alu_arb #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic [3:0]            r0_req_op,
  input  logic [DATA_WIDTH-1:0] r0_req_a,
  input  logic [DATA_WIDTH-1:0] r0_req_b,
  output logic                  r0_rsp_valid,
  input  logic                  r0_rsp_ready,
  output logic [DATA_WIDTH-1:0] r0_rsp_data,
  output logic                  r0_rsp_ovf,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic [3:0]            r1_req_op,
  input  logic [DATA_WIDTH-1:0] r1_req_a,
  input  logic [DATA_WIDTH-1:0] r1_req_b,
  output logic                  r1_rsp_valid,
  input  logic                  r1_rsp_ready,
  output logic [DATA_WIDTH-1:0] r1_rsp_data,
  output logic                  r1_rsp_ovf,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_last_grant;
  logic                  r_id;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ovf;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;
  logic w_rsp_hs;

  assign w_idle = (r_state == ST_IDLE);

  // Round-robin: on a tie the requester that was not granted last wins.
  assign w_gnt0 = r0_req_valid & (~r1_req_valid | r_last_grant);
  assign w_gnt1 = r1_req_valid & (~r0_req_valid | ~r_last_grant);

  // flush blocks acceptance, so ready is withheld too; a requester never sees a
  // handshake that the arbiter then ignores.
  assign r0_req_ready = w_idle & ~flush & w_gnt0;
  assign r1_req_ready = w_idle & ~flush & w_gnt1;
  assign w_accept     = r0_req_ready | r1_req_ready;

  assign r0_rsp_valid = (r_state == ST_RESP) & ~r_id;
  assign r1_rsp_valid = (r_state == ST_RESP) & r_id;
  // Only the issuing requester's rsp_ready can complete the response.
  assign w_rsp_hs     = r_id ? (r1_rsp_valid & r1_rsp_ready) : (r0_rsp_valid & r0_rsp_ready);

  assign r0_rsp_data = r_data;
  assign r1_rsp_data = r_data;
  assign r0_rsp_ovf  = r_ovf;
  assign r1_rsp_ovf  = r_ovf;

  // Operand registers only change on acceptance, so the ALU inputs stay quiet
  // outside EXEC.
  assign alu_A  = r_a;
  assign alu_B  = r_b;
  assign alu_op = r_op;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
        ST_EXEC: w_state_nxt = ST_RESP;
        ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_data       <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_id         <= r1_req_ready;
        r_last_grant <= r1_req_ready;
        r_op         <= r1_req_ready ? r1_req_op : r0_req_op;
        r_a          <= r1_req_ready ? r1_req_a : r0_req_a;
        r_b          <= r1_req_ready ? r1_req_b : r0_req_b;
      end
      if ((r_state == ST_EXEC) && !flush) begin
        r_data <= alu_result;
        r_ovf  <= alu_overflow;
      end
    end
  end

endmodule

// File: tb/tb_mycpu_alu_arb.sv
// Bench for mycpu_alu_arb: directed scenarios with literal expectations plus a
// transaction-level reference model checked every cycle.
module tb_mycpu_alu_arb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        r0_req_valid = 1'b0, r1_req_valid = 1'b0;
  logic        r0_req_ready, r1_req_ready;
  logic [3:0]  r0_req_op = '0, r1_req_op = '0;
  logic [31:0] r0_req_a = '0, r0_req_b = '0, r1_req_a = '0, r1_req_b = '0;
  logic        r0_rsp_valid, r1_rsp_valid;
  logic        r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
  logic [31:0] r0_rsp_data, r1_rsp_data;
  logic        r0_rsp_ovf, r1_rsp_ovf;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [3:0]  alu_op;
  logic        alu_overflow;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Shared ALU environment: 0 = add, 1 = sub, otherwise xor.
  logic [31:0] w_sum, w_dif;
  assign w_sum = alu_A + alu_B;
  assign w_dif = alu_A - alu_B;
  assign alu_result = (alu_op == 4'd0) ? w_sum : (alu_op == 4'd1) ? w_dif : (alu_A ^ alu_B);
  assign alu_overflow =
      (alu_op == 4'd0) ? ((alu_A[31] == alu_B[31]) && (w_sum[31] != alu_A[31])) :
      (alu_op == 4'd1) ? ((alu_A[31] != alu_B[31]) && (w_dif[31] != alu_A[31])) : 1'b0;

  mycpu_alu_arb #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_op(r0_req_op),
    .r0_req_a(r0_req_a), .r0_req_b(r0_req_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_data(r0_rsp_data), .r0_rsp_ovf(r0_rsp_ovf),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_op(r1_req_op),
    .r1_req_a(r1_req_a), .r1_req_b(r1_req_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_data(r1_rsp_data), .r1_rsp_ovf(r1_rsp_ovf),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Signed-arithmetic reference: returns {overflow, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, r;
    logic   ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0) r = sa + sb;
    else if (op == 4'd1) r = sa - sb;
    else return {1'b0, a ^ b};
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ov, r[31:0]};
  endfunction

  // Reference model: an operation is "busy" from acceptance until its response is
  // consumed; m_age counts edges since acceptance (response visible from age 2).
  bit          m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_ovf = 1'b0;
  int          m_age = 0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;

  always begin : compare
    bit e_rdy0, e_rdy1, e_rv0, e_rv1;
    @(negedge clk);
    #4;
    if (!resetn) begin
      m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = '0;
    end
    e_rdy0 = !m_busy && !flush && r0_req_valid && (!r1_req_valid || m_last);
    e_rdy1 = !m_busy && !flush && r1_req_valid && (!r0_req_valid || !m_last);
    e_rv0  = m_busy && (m_age >= 2) && !m_id;
    e_rv1  = m_busy && (m_age >= 2) && m_id;
    chk("m_r0_req_ready", r0_req_ready, e_rdy0);
    chk("m_r1_req_ready", r1_req_ready, e_rdy1);
    chk("m_r0_rsp_valid", r0_rsp_valid, e_rv0);
    chk("m_r1_rsp_valid", r1_rsp_valid, e_rv1);
    chk("m_alu_A", alu_A, m_a);
    chk("m_alu_B", alu_B, m_b);
    chk("m_alu_op", alu_op, m_op);
    if (e_rv0) begin
      chk("m_r0_rsp_data", r0_rsp_data, m_res);
      chk("m_r0_rsp_ovf", r0_rsp_ovf, m_ovf);
    end
    if (e_rv1) begin
      chk("m_r1_rsp_data", r1_rsp_data, m_res);
      chk("m_r1_rsp_ovf", r1_rsp_ovf, m_ovf);
    end
    if (resetn) begin
      if (flush) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (e_rdy0 || e_rdy1) begin
          m_id   = e_rdy1;
          m_op   = e_rdy1 ? r1_req_op : r0_req_op;
          m_a    = e_rdy1 ? r1_req_a : r0_req_a;
          m_b    = e_rdy1 ? r1_req_b : r0_req_b;
          {m_ovf, m_res} = ref_alu(m_op, m_a, m_b);
          m_last = m_id;
          m_busy = 1'b1;
          m_age  = 1;
        end
      end else if (m_age < 2) begin
        m_age = m_age + 1;
      end else if (m_id ? r1_rsp_ready : r0_rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Tasks start at a falling edge; waits end 4 time units after it on a hit.
  task automatic do_reset();
    resetn = 1'b0; flush = 1'b0;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_ready(input bit id, input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #4;
      if (id ? r1_req_ready : r0_req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_rsp(input bit id, input string nm);
    bit ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #4;
      if (id ? r1_rsp_valid : r0_rsp_valid) ok = 1'b1;
      else @(negedge clk);
    end
    chk(nm, ok, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int who;
    @(negedge clk);
    #4;
    chk("rst_r0_req_ready", r0_req_ready, 1'b0);
    chk("rst_r0_rsp_data", r0_rsp_data, 32'h0);
    chk("rst_alu_A", alu_A, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Single add: ready at N, response at N+2.
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_req_valid = 1'b1; r0_req_op = 4'd0; r0_req_a = 32'd5; r0_req_b = 32'd7;
    #4 chk("single_ready_N", r0_req_ready, 1'b1);
    @(negedge clk);
    r0_req_valid = 1'b0;
    #4 chk("single_rsp_N1", r0_rsp_valid, 1'b0);
    chk("single_aluA_N1", alu_A, 32'd5);
    @(negedge clk);
    #4 chk("single_rsp_N2", r0_rsp_valid, 1'b1);
    chk("single_data", r0_rsp_data, 32'd12);
    chk("single_ovf", r0_rsp_ovf, 1'b0);
    @(negedge clk);
    #4 chk("single_consumed", r0_rsp_valid, 1'b0);
    @(negedge clk);

    // Tie after reset: r0 first, then strict alternation.
    do_reset();
    r0_req_valid = 1'b1; r0_req_op = 4'd0; r0_req_a = 32'd1;  r0_req_b = 32'd2;
    r1_req_valid = 1'b1; r1_req_op = 4'd1; r1_req_a = 32'd10; r1_req_b = 32'd3;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int t = 0; t < 20 && who < 0; t++) begin
        #4;
        if (r0_req_ready) who = 0;
        else if (r1_req_ready) who = 1;
        @(negedge clk);
      end
      chk($sformatf("tie_grant%0d", k), who, k % 2);
      if (who == 0) r0_req_a = r0_req_a + 32'd100;
      else if (who == 1) r1_req_a = r1_req_a + 32'd100;
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure with signed overflow; r0 waits behind the held response.
    do_reset();
    r1_rsp_ready = 1'b0;
    r1_req_valid = 1'b1; r1_req_op = 4'd0; r1_req_a = 32'h7FFF_FFFF; r1_req_b = 32'd1;
    wait_ready(1'b1, "bp_accept");
    @(negedge clk);
    r1_req_valid = 1'b0;
    r0_req_valid = 1'b1; r0_req_op = 4'd2; r0_req_a = 32'd3; r0_req_b = 32'd5;
    wait_rsp(1'b1, "bp_rsp");
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #4;
      chk("bp_hold_valid", r1_rsp_valid, 1'b1);
      chk("bp_hold_data", r1_rsp_data, 32'h8000_0000);
      chk("bp_hold_ovf", r1_rsp_ovf, 1'b1);
      chk("bp_no_accept", r0_req_ready, 1'b0);
      @(negedge clk);
    end
    r1_rsp_ready = 1'b1;
    #4 chk("bp_hs_no_accept", r0_req_ready, 1'b0);
    @(negedge clk);
    #4 chk("bp_next_accept", r0_req_ready, 1'b1);
    @(negedge clk);
    r0_req_valid = 1'b0;
    wait_rsp(1'b0, "bp_r0_rsp");
    chk("bp_r0_data", r0_rsp_data, 32'd6);
    @(negedge clk);
    @(negedge clk);

    // Flush in EXEC with r1 pending.
    do_reset();
    r0_req_valid = 1'b1; r0_req_op = 4'd0; r0_req_a = 32'd1; r0_req_b = 32'd1;
    wait_ready(1'b0, "fe_accept");
    @(negedge clk);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b1; r1_req_op = 4'd0; r1_req_a = 32'd2; r1_req_b = 32'd2;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #4 chk("fe_no_rsp", r0_rsp_valid, 1'b0);
    chk("fe_pending_ready", r1_req_ready, 1'b1);
    @(negedge clk);
    r1_req_valid = 1'b0;
    wait_rsp(1'b1, "fe_r1_rsp");
    chk("fe_r1_data", r1_rsp_data, 32'd4);
    @(negedge clk);
    @(negedge clk);

    // Flush in RESP while the response is back-pressured.
    r0_rsp_ready = 1'b0;
    r0_req_valid = 1'b1; r0_req_op = 4'd1; r0_req_a = 32'd9; r0_req_b = 32'd4;
    wait_ready(1'b0, "fr_accept");
    @(negedge clk);
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b1; r1_req_op = 4'd2; r1_req_a = 32'hF0; r1_req_b = 32'h0F;
    wait_rsp(1'b0, "fr_rsp");
    chk("fr_data", r0_rsp_data, 32'd5);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #4 chk("fr_no_rsp", r0_rsp_valid, 1'b0);
    chk("fr_pending_ready", r1_req_ready, 1'b1);
    @(negedge clk);
    r1_req_valid = 1'b0;
    r0_rsp_ready = 1'b1;
    wait_rsp(1'b1, "fr_r1_rsp");
    chk("fr_r1_data", r1_rsp_data, 32'hFF);
    @(negedge clk);
    @(negedge clk);

    // Reset pulse mid-RESP: valid drops without a clock edge; r0 wins the next tie.
    r1_rsp_ready = 1'b0;
    r1_req_valid = 1'b1; r1_req_op = 4'd0; r1_req_a = 32'd3; r1_req_b = 32'd4;
    wait_ready(1'b1, "rr_accept");
    @(negedge clk);
    r1_req_valid = 1'b0;
    wait_rsp(1'b1, "rr_rsp");
    @(negedge clk);
    resetn = 1'b0;
    #4 chk("rr_async_drop", r1_rsp_valid, 1'b0);
    chk("rr_data_cleared", r1_rsp_data, 32'h0);
    @(negedge clk);
    r0_req_valid = 1'b1; r0_req_op = 4'd0; r0_req_a = 32'd20; r0_req_b = 32'd22;
    r1_req_valid = 1'b1; r1_req_op = 4'd0; r1_req_a = 32'd30; r1_req_b = 32'd33;
    r1_rsp_ready = 1'b1; r0_rsp_ready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    #4 chk("rr_tie_r0", r0_req_ready, 1'b1);
    chk("rr_tie_not_r1", r1_req_ready, 1'b0);
    chk("rr_no_stale_rsp", r1_rsp_valid, 1'b0);
    @(negedge clk);
    r0_req_valid = 1'b0;
    wait_rsp(1'b0, "rr_r0_rsp");
    chk("rr_r0_data", r0_rsp_data, 32'd42);
    @(negedge clk);
    wait_ready(1'b1, "rr_r1_accept");
    @(negedge clk);
    r1_req_valid = 1'b0;
    wait_rsp(1'b1, "rr_r1_rsp");
    chk("rr_r1_data", r1_rsp_data, 32'd63);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mycpu_alu_arb.md
MYCPU_ALU_ARB -- requirements
Module: myCPU_alu_arb

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand/result width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: flush  input  1  synchronous abort of the in-flight operation.
REQ-005 Ports: rN_req_valid  input  1  request N valid (N=0,1).
REQ-006 Ports: rN_req_ready  output  1  request N accepted when valid&ready.
REQ-007 Ports: rN_req_op  input  4  ALU opcode, passed through unmodified.
REQ-008 Ports: rN_req_a, rN_req_b  input  DATA_WIDTH  operands A, B.
REQ-009 Ports: rN_rsp_valid  output  1  response N valid.
REQ-010 Ports: rN_rsp_ready  input  1  response N consumed when valid&ready.
REQ-011 Ports: rN_rsp_data  output  DATA_WIDTH  ALU result for requester N.
REQ-012 Ports: rN_rsp_ovf  output  1  ALU overflow flag for requester N.
REQ-013 Ports: alu_A, alu_B  output  DATA_WIDTH  operands to shared ALU.
REQ-014 Port: alu_op  output  4  opcode to shared ALU.
REQ-015 Ports: alu_result  input  DATA_WIDTH; alu_overflow  input  1  combinational ALU outputs.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at most.
REQ-017 In IDLE, rN_req_ready SHALL be asserted only for the granted requester; both deasserted in EXEC and RESP.
REQ-018 Grant SHALL be combinational in IDLE: one valid wins; both valid -> requester not granted last (round-robin).
REQ-019 last_grant SHALL update only on an accepted request.
REQ-020 On acceptance (cycle N) opcode, A, B and requester id SHALL be registered; FSM -> EXEC.
REQ-021 In EXEC (cycle N+1) alu_A/alu_B/alu_op SHALL be driven from the registers; alu_result and alu_overflow captured at the end of N+1; FSM -> RESP.
REQ-022 In RESP (from N+2) rN_rsp_valid SHALL be asserted only for the issuing requester, with data/ovf stable until rN_rsp_ready.
REQ-023 On rsp handshake, FSM SHALL -> IDLE; a new request is not accepted in that same cycle (minimum 3 cycles per operation).
REQ-024 The non-issuing requester's rsp_valid SHALL stay 0; its rsp_ready SHALL be ignored.
REQ-025 Outside EXEC, alu_A/alu_B/alu_op SHALL hold the last registered values (no toggling).
REQ-026 flush SHALL force IDLE next cycle, deassert all rsp_valid, discard the in-flight op; flush beats simultaneous req or rsp handshake (no acceptance, no consumption counted).
REQ-027 Requests SHALL not be dropped: a valid not granted SHALL remain pending until granted; with both continuously valid, grants SHALL alternate 0,1,0,1.
REQ-028 Opcode SHALL be opaque; no decoding, no width change of operands/result.

Reset
REQ-029 resetn low SHALL immediately force IDLE, all rsp_valid=0, req_ready per IDLE grant logic with no valid -> 0.
REQ-030 Reset values: operand/opcode registers 0, rsp_data 0, rsp_ovf 0, last_grant=1 (requester 0 wins first tie).
REQ-031 Reset asserted mid-EXEC or mid-RESP SHALL abandon the operation with no response emitted after release.

Verification
REQ-032 Single: r0 valid, op=add code, A=5, B=7 at cycle N -> r0_req_ready at N, r0_rsp_valid at N+2 with data=alu_result (12), ovf=0.
REQ-033 Tie: r0,r1 both valid after reset -> r0 granted first, r1 granted in first IDLE after r0 response consumed; then alternation over 4 ops.
REQ-034 Backpressure: r1_rsp_ready=0 for 5 cycles -> r1_rsp_valid, data, ovf held stable; no new request accepted until handshake.
REQ-035 Overflow: ALU model returns alu_overflow=1 for A=0x7FFFFFFF, B=1 -> rsp_ovf=1 with data=0x80000000.
REQ-036 Flush in EXEC and in RESP -> no rsp_valid on the following cycle, FSM in IDLE, pending request accepted next.
REQ-037 resetn pulsed low mid-RESP -> rsp_valid drops asynchronously; after release, tie goes to r0.
